// File: rtl/rv32i_types.sv
// Shared rv32i pipeline types: IF/ID register layout, fetch FSM states, reset PC.
package rv32i_types;

  localparam logic [31:0] RESET_PC_DEFAULT = 32'h1eceb000;

  typedef enum logic [1:0] {
    IDLE,
    WAIT,
    FLUSH
  } fetch_state_t;

  typedef struct packed {
    logic        valid;
    logic [31:0] pc;
    logic [31:0] inst;
    logic [63:0] order;
  } if_id_reg_t;

endpackage

// File: rtl/fetch_skid.sv
// One-entry skid plus output slot; a blocked push lands in the skid, which drains into the slot first.
// Zero-latency handoff into the slot; clr_i drops both entries and wins over push and drain.
module fetch_skid
  import rv32i_types::*;
(
  input  logic       clk,
  input  logic       rst,
  input  logic       clr_i,
  input  logic       push_i,
  input  if_id_reg_t push_dat_i,
  input  logic       stall_i,
  output if_id_reg_t slot_o,
  output logic       skid_vld_d_o
`ifdef FETCH_PERF_EN
  ,
  output logic       skid_vld_o
`endif
);

  if_id_reg_t slot_q, slot_d;
  if_id_reg_t skid_q, skid_d;
  logic       consume;
  logic       slot_free;

  assign consume   = slot_q.valid && !stall_i;
  assign slot_free = !slot_q.valid || !stall_i;

  always_comb begin
    slot_d = slot_q;
    skid_d = skid_q;
    if (clr_i) begin
      slot_d.valid = 1'b0;
      skid_d.valid = 1'b0;
    end else if (skid_q.valid) begin
      // Older skid entry must reach the slot before any newer response.
      if (consume) begin
        slot_d       = skid_q;
        skid_d.valid = 1'b0;
        if (push_i) skid_d = push_dat_i;
      end
    end else if (push_i) begin
      if (slot_free) slot_d = push_dat_i;
      else           skid_d = push_dat_i;
    end else if (consume) begin
      slot_d.valid = 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      slot_q <= '0;
      skid_q <= '0;
    end else begin
      slot_q <= slot_d;
      skid_q <= skid_d;
    end
  end

  assign slot_o       = slot_q;
  assign skid_vld_d_o = skid_d.valid;
`ifdef FETCH_PERF_EN
  assign skid_vld_o   = skid_q.valid;
`endif

endmodule

// File: rtl/fetch_stage.sv
// rv32i fetch: one outstanding imem read, response-to-if_id_reg latency 1, stall absorbed by a 1-entry skid.
// Redirect squashes slot, skid and any in-flight response. FETCH_PERF_EN adds fetched/squashed counters.
module fetch_stage
  import rv32i_types::*;
#(
  parameter logic [31:0] RESET_PC = RESET_PC_DEFAULT
) (
  input  logic        clk,
  input  logic        rst,
  output logic [31:0] imem_addr,
  output logic [3:0]  imem_rmask,
  input  logic [31:0] imem_rdata,
  input  logic        imem_resp,
  input  logic        stall,
  input  logic        redirect_valid,
  input  logic [31:0] redirect_pc,
  input  logic [63:0] redirect_order,
  output if_id_reg_t  if_id_reg
`ifdef FETCH_PERF_EN
  ,
  output logic [31:0] perf_fetched,
  output logic [31:0] perf_squashed
`endif
);

  fetch_state_t state_q, state_d;
  logic [31:0]  pc_q, pc_d;
  logic [63:0]  order_q, order_d;
  logic [31:0]  redir_pc_aligned;
  logic         accept;
  logic         drop;
  logic         issue;
  logic         skid_vld_nxt;
  if_id_reg_t   push_dat;

  assign redir_pc_aligned = redirect_pc & 32'hffff_fffc;

  // pc_q still holds the outstanding request's PC until the response is accepted.
  assign accept   = (state_q == WAIT) && imem_resp && !redirect_valid;
  assign drop     = imem_resp && (((state_q == WAIT) && redirect_valid) || (state_q == FLUSH));
  assign issue    = !rst && !redirect_valid && ((state_q == IDLE) || accept) && !skid_vld_nxt;
  assign push_dat = {1'b1, pc_q, imem_rdata, order_q};

  always_comb begin
    state_d = state_q;
    pc_d    = pc_q;
    order_d = order_q;
    if (redirect_valid) begin
      pc_d    = redir_pc_aligned;
      order_d = redirect_order;
      unique case (state_q)
        WAIT:    state_d = imem_resp ? IDLE : FLUSH;
        FLUSH:   state_d = imem_resp ? IDLE : FLUSH;
        default: state_d = IDLE;
      endcase
    end else begin
      if (accept) begin
        pc_d    = pc_q + 32'd4;
        order_d = order_q + 64'd1;
      end
      if (issue)                                        state_d = WAIT;
      else if (accept || (state_q == FLUSH && imem_resp)) state_d = IDLE;
    end
  end

  // The address issued alongside an accept is already the incremented PC.
  assign imem_rmask = issue ? 4'hf : 4'h0;
  assign imem_addr  = issue ? pc_d : 32'h0;

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      pc_q    <= RESET_PC;
      order_q <= '0;
    end else begin
      state_q <= state_d;
      pc_q    <= pc_d;
      order_q <= order_d;
    end
  end

`ifdef FETCH_PERF_EN
  logic        skid_vld;
  logic [31:0] squash_inc;
`endif

  fetch_skid u_skid (
    .clk          (clk),
    .rst          (rst),
    .clr_i        (redirect_valid),
    .push_i       (accept),
    .push_dat_i   (push_dat),
    .stall_i      (stall),
    .slot_o       (if_id_reg),
    .skid_vld_d_o (skid_vld_nxt)
`ifdef FETCH_PERF_EN
    ,
    .skid_vld_o   (skid_vld)
`endif
  );

`ifdef FETCH_PERF_EN
  assign squash_inc = 32'(drop)
                    + 32'(redirect_valid && if_id_reg.valid)
                    + 32'(redirect_valid && skid_vld);

  always_ff @(posedge clk) begin
    if (rst) begin
      perf_fetched  <= '0;
      perf_squashed <= '0;
    end else begin
      perf_fetched  <= perf_fetched + 32'(accept);
      perf_squashed <= perf_squashed + squash_inc;
    end
  end
`else
  logic unused_drop;
  assign unused_drop = drop;
`endif

endmodule

// File: tb/tb_fetch_stage.sv
// Randomized bench for fetch_stage: memory model with variable latency, expected instruction stream
// regenerated at every reset/redirect and checked by an independent monitor.
module tb_fetch_stage;
  import rv32i_types::*;

  localparam logic [31:0] RPC = 32'h1eceb000;

  logic        clk = 1'b0;
  logic        rst;
  logic [31:0] imem_addr;
  logic [3:0]  imem_rmask;
  logic [31:0] imem_rdata;
  logic        imem_resp;
  logic        stall;
  logic        redirect_valid;
  logic [31:0] redirect_pc;
  logic [63:0] redirect_order;
  if_id_reg_t  if_id_reg;
`ifdef FETCH_PERF_EN
  logic [31:0] perf_fetched;
  logic [31:0] perf_squashed;
`endif

  fetch_stage dut (
    .clk            (clk),
    .rst            (rst),
    .imem_addr      (imem_addr),
    .imem_rmask     (imem_rmask),
    .imem_rdata     (imem_rdata),
    .imem_resp      (imem_resp),
    .stall          (stall),
    .redirect_valid (redirect_valid),
    .redirect_pc    (redirect_pc),
    .redirect_order (redirect_order),
    .if_id_reg      (if_id_reg)
`ifdef FETCH_PERF_EN
    ,
    .perf_fetched   (perf_fetched),
    .perf_squashed  (perf_squashed)
`endif
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [31:0] addr;
    int          due;
  } req_t;

  int         n_vec = 0;
  int         n_err = 0;
  int         cyc = 0;
  int         lat_lo = 1;
  int         lat_hi = 1;
  bit         inject_stale = 1'b0;
  req_t       pend[$];
  if_id_reg_t exp_q[$];

  function automatic logic [31:0] memf(input logic [31:0] a);
    return (a * 32'h9e3779b1) ^ 32'h5a5a5a5a;
  endfunction

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // Expected program stream from a new starting point: sequential PCs and orders.
  task automatic refill(input logic [31:0] pc, input logic [63:0] ord);
    if_id_reg_t e;
    exp_q.delete();
    for (int i = 0; i < 512; i++) begin
      e.valid = 1'b1;
      e.pc    = pc;
      e.inst  = memf(pc);
      e.order = ord;
      exp_q.push_back(e);
      pc  = pc + 32'd4;
      ord = ord + 64'd1;
    end
  endtask

  task automatic step(input bit r, input bit s, input bit rv,
                      input logic [31:0] rpc, input logic [63:0] rord);
    req_t q;
    @(negedge clk);
    cyc++;
    rst            = r;
    stall          = s;
    redirect_valid = rv;
    redirect_pc    = rpc;
    redirect_order = rord;
    imem_resp      = 1'b0;
    imem_rdata     = 32'h0;
    if (pend.size() > 0 && pend[0].due <= cyc) begin
      imem_resp  = 1'b1;
      imem_rdata = memf(pend[0].addr);
      void'(pend.pop_front());
    end else if (inject_stale) begin
      imem_resp  = 1'b1;
      imem_rdata = 32'hdeadbeef;
    end
    inject_stale = 1'b0;
    if (r) begin
      pend.delete();
      refill(RPC, 64'd0);
    end else if (rv) begin
      refill(rpc & 32'hffff_fffc, rord);
    end
    #1;
    if (!r && imem_rmask != 4'h0) begin
      chk("rmask_full", 64'(imem_rmask), 64'hf);
      chk("one_outstanding", 64'(pend.size()), 64'd0);
      q.addr = imem_addr;
      q.due  = cyc + int'($urandom_range(lat_hi, lat_lo));
      pend.push_back(q);
    end
  endtask

  task automatic idle();
    step(1'b0, 1'b0, 1'b0, 32'h0, 64'h0);
  endtask

  task automatic wait_req(input int max_cyc);
    bit seen;
    seen = 1'b0;
    for (int i = 0; i < max_cyc && !seen; i++) begin
      idle();
      seen = (imem_rmask == 4'hf);
    end
    if (!seen) begin
      n_vec++;
      n_err++;
      $display("FAIL wait_req: got no request, expected one within %0d cycles", max_cyc);
    end
  endtask

  // Monitor: pops the expected stream whenever decode consumes the slot.
  if_id_reg_t prev;
  bit         prev_hold = 1'b0;
  always @(negedge clk) begin
    if_id_reg_t e;
    #2;
    if (rst) begin
      prev_hold = 1'b0;
    end else begin
      if (prev_hold) begin
        n_vec++;
        if (if_id_reg !== prev) begin
          n_err++;
          $display("FAIL stall_stable: got pc %h order %0d expected pc %h order %0d",
                   if_id_reg.pc, if_id_reg.order, prev.pc, prev.order);
        end
      end
      if (!redirect_valid && if_id_reg.valid && !stall) begin
        n_vec++;
        if (exp_q.size() == 0) begin
          n_err++;
          $display("FAIL stream_underflow: got pc %h, expected no delivery", if_id_reg.pc);
        end else begin
          e = exp_q.pop_front();
          if (if_id_reg !== e) begin
            n_err++;
            $display("FAIL stream: got pc %h inst %h order %0d expected pc %h inst %h order %0d",
                     if_id_reg.pc, if_id_reg.inst, if_id_reg.order, e.pc, e.inst, e.order);
          end
        end
      end
      prev      = if_id_reg;
      prev_hold = if_id_reg.valid && stall && !redirect_valid;
    end
  end

  initial begin
    rst = 1'b1; stall = 1'b0; redirect_valid = 1'b0; redirect_pc = '0;
    redirect_order = '0; imem_resp = 1'b0; imem_rdata = '0;

    // Reset state
    step(1'b1, 1'b0, 1'b0, 32'h0, 64'h0);
    step(1'b1, 1'b0, 1'b0, 32'h0, 64'h0);
    chk("rst_valid", 64'(if_id_reg.valid), 64'd0);
    chk("rst_pc", 64'(if_id_reg.pc), 64'd0);
    chk("rst_inst", 64'(if_id_reg.inst), 64'd0);
    chk("rst_order", if_id_reg.order, 64'd0);
    chk("rst_rmask", 64'(imem_rmask), 64'd0);
    chk("rst_addr", 64'(imem_addr), 64'd0);

    // Reset release, 1-cycle memory: back-to-back requests
    idle();
    chk("req0_addr", 64'(imem_addr), 64'(RPC));
    chk("req0_slot_empty", 64'(if_id_reg.valid), 64'd0);
    idle();
    chk("req1_addr", 64'(imem_addr), 64'(RPC + 32'd4));
    chk("req1_slot_empty", 64'(if_id_reg.valid), 64'd0);
    idle();
    chk("req2_addr", 64'(imem_addr), 64'(RPC + 32'd8));
    chk("first_valid", 64'(if_id_reg.valid), 64'd1);
    chk("first_order", if_id_reg.order, 64'd0);

    // Stall 3 cycles with slot holding ...004 and ...008 returning into the skid
    step(1'b0, 1'b1, 1'b0, 32'h0, 64'h0);
    chk("stall_slot_pc", 64'(if_id_reg.pc), 64'(RPC + 32'd4));
    chk("stall_no_req0", 64'(imem_rmask), 64'd0);
    step(1'b0, 1'b1, 1'b0, 32'h0, 64'h0);
    chk("stall_no_req1", 64'(imem_rmask), 64'd0);
    step(1'b0, 1'b1, 1'b0, 32'h0, 64'h0);
    chk("stall_no_req2", 64'(imem_rmask), 64'd0);
    chk("stall_slot_order", if_id_reg.order, 64'd1);
    idle();
    chk("release_addr", 64'(imem_addr), 64'(RPC + 32'd12));
    idle();
    chk("drain_pc", 64'(if_id_reg.pc), 64'(RPC + 32'd8));
    repeat (4) idle();

    // Redirect one cycle before the response of a 2-cycle read
    lat_lo = 2; lat_hi = 2;
    wait_req(8);
    step(1'b0, 1'b0, 1'b1, 32'h1eceb100, 64'd7);
    idle();
    chk("flush_no_req", 64'(imem_rmask), 64'd0);
    wait_req(8);
    chk("redir_addr", 64'(imem_addr), 64'h1eceb100);
    lat_lo = 1; lat_hi = 1;
    repeat (5) idle();

    // Redirect + response + stall in the same cycle
    step(1'b0, 1'b1, 1'b1, 32'h1eceb200, 64'd100);
    idle();
    chk("simul_slot_cleared", 64'(if_id_reg.valid), 64'd0);
    chk("simul_req", 64'(imem_rmask), 64'hf);
    chk("simul_addr", 64'(imem_addr), 64'h1eceb200);
    repeat (4) idle();

    // Misaligned redirect with order about to wrap
    step(1'b0, 1'b0, 1'b1, 32'h80000003, 64'hffff_ffff_ffff_fffe);
    wait_req(8);
    chk("misalign_addr", 64'(imem_addr), 64'h80000000);
    repeat (5) idle();

    // PC wrap
    step(1'b0, 1'b0, 1'b1, 32'hfffffff8, 64'd55);
    repeat (8) idle();

    // Reset while a 3-cycle read is outstanding; stale response right after release
    lat_lo = 3; lat_hi = 3;
    wait_req(8);
    step(1'b1, 1'b0, 1'b0, 32'h0, 64'h0);
    step(1'b1, 1'b0, 1'b0, 32'h0, 64'h0);
    lat_lo = 1; lat_hi = 2;
    inject_stale = 1'b1;
    idle();
    chk("rst_mid_addr", 64'(imem_addr), 64'(RPC));
    repeat (8) idle();

    // Random traffic
    lat_lo = 1; lat_hi = 4;
    for (int i = 0; i < 3000; i++) begin
      bit          r, s, rv;
      logic [31:0] rp;
      logic [63:0] ro;
      r  = ($urandom % 400) == 0;
      s  = ($urandom % 10) < 3;
      rv = ($urandom % 32) == 0;
      case ($urandom % 3)
        0:       rp = $urandom;
        1:       rp = 32'hfffffff0 | ($urandom % 16);
        default: rp = RPC + ($urandom % 64) * 4;
      endcase
      ro = ($urandom % 2) ? {$urandom, $urandom} : 64'hffff_ffff_ffff_fff0 + 64'($urandom % 16);
      step(r, s, rv, rp, ro);
    end
    repeat (10) idle();

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule

// File: doc/fetch_stage.md
# fetch_stage

Instruction-fetch front end of the rv32i pipeline: owns the PC, issues word reads on the instruction-memory port, and delivers fetched instructions to decode through `if_id_reg`. It is the requesting end of the imem interface that decode consumes. It holds one outstanding request, absorbs downstream stalls with a one-entry skid buffer, and handles control-flow redirects, including squashing an in-flight response.

## Interface
- `RESET_PC`, default `32'h1eceb000`: PC of the first fetch after reset.
- `clk`  in  1  clock.
- `rst`  in  1  synchronous, active-high reset.
- `imem_addr`  out  32  word-aligned fetch address; valid when `imem_rmask != 0`.
- `imem_rmask`  out  4  `4'hf` for a 1-cycle request pulse; `4'h0` otherwise.
- `imem_rdata`  in  32  instruction word; valid when `imem_resp`.
- `imem_resp`  in  1  response strobe, at least 1 cycle after its request.
- `stall`  in  1  decode cannot accept; `if_id_reg` must hold.
- `redirect_valid`  in  1  branch/jump/flush from execute.
- `redirect_pc`  in  32  new PC; bits [1:0] are ignored and forced to 0.
- `redirect_order`  in  64  order assigned to the first instruction fetched after the redirect.
- `if_id_reg`  out  `if_id_reg_t`  registered fields: `{valid, pc, inst, order}`.

## Operation
- State: `pc`, `order`, FSM `{IDLE, WAIT, FLUSH}`, output slot (`if_id_reg`), and a skid entry `{skid_valid, pc, inst, order}`.
- `slot_free = !if_id_reg.valid || !stall`.
- **Issue condition:** `!redirect_valid && (state==IDLE || (state==WAIT && imem_resp)) && skid empty at end of cycle`.
  - On issue: `imem_addr = pc`, `imem_rmask = 4'hf`, next state WAIT.
- **Accepted response** (WAIT, `imem_resp`, no redirect):
  - Entry `{1, pc_of_req, imem_rdata, order}` goes to the output slot if `slot_free`, otherwise to the skid.
  - Then `pc += 4` and `order += 1`.
  - Next state is WAIT if a new request is issued this cycle, otherwise IDLE.
- **Skid drain:** when the slot is consumed (`valid && !stall`) and the skid is full, the skid moves to the slot. A response arriving in the same cycle goes to the skid.
- **Redirect** has the highest priority, over stall and response:
  - `pc <= {redirect_pc[31:2], 2'b00}` and `order <= redirect_order`.
  - Slot valid and skid valid are both cleared.
  - No request is issued that cycle.
  - From WAIT without `imem_resp`: go to FLUSH. From WAIT with `imem_resp`: drop the response and go to IDLE. From IDLE: stay in IDLE.
- **FLUSH:** wait for `imem_resp`, drop it, go to IDLE. A redirect during FLUSH updates `pc`/`order` and stays in FLUSH.
- **Arithmetic:** PC increments wrap modulo 2^32. `order` is 64-bit and wraps.

## Timing
- **Reset** (any cycle, including mid-request): `pc = RESET_PC`, `order = 0`, state IDLE, `if_id_reg` all fields zero, skid empty, `imem_rmask = 0`, `imem_addr = 0`. Any response arriving after reset is ignored because the state is IDLE.
- First request is in the first cycle with `rst` low.
- **Latency:** request at t, response at t+k, `if_id_reg.valid` at t+k+1.
- **Throughput:** with 1-cycle memory and no stall, one instruction per cycle.
- `if_id_reg` is stable while `valid && stall`.
- An instruction is never duplicated or lost across stall, skid, or drain.

## Configuration
- **`FETCH_PERF_EN` defined:** two 32-bit outputs, `perf_fetched` and `perf_squashed`, reset to 0.
  - `perf_fetched` increments on each accepted response.
  - `perf_squashed` increments on each dropped response plus each valid slot or skid entry cleared by a redirect (0, 1, or 2 per cycle).
- **`FETCH_PERF_EN` undefined:** the ports and logic are absent. Functional behaviour is identical either way.

## Structure
- `rv32i_types` holds:
  - `if_id_reg_t`, which gains `valid` and `inst` alongside `pc` and `order`.
  - A `fetch_state_t` enum.
  - A `RESET_PC` default constant.
- One sub-module: `fetch_skid`, the one-entry skid/output register pair with the `stall` handshake and a clear input.

## Test plan
- **Reset release:** `rst` 1→0 with 1-cycle memory → requests to `0x1eceb000`, `0x1eceb004`, `0x1eceb008` on consecutive cycles; `if_id_reg.order` = 0, 1, 2.
- **Stall:** hold `stall` for 3 cycles while responses return → slot holds `pc 0x1eceb004`, skid holds `0x1eceb008`, no further request is issued. On release, outputs are 0x…04 then 0x…08 with no gap or duplicate.
- **Redirect in WAIT:** redirect to `0x1eceb100` with `redirect_order = 7` one cycle before `imem_resp` → the response is dropped, the next request goes to `0x1eceb100`, and its output has `order = 7`.
- **Simultaneous events:** redirect in the same cycle as `imem_resp` plus `stall` → slot cleared and response dropped; next cycle a request to the redirect PC is issued.
- **Reset mid-request:** `rst` asserted while in WAIT, with `imem_resp` arriving the cycle after `rst` is released → that stale response is dropped, and the fetch from `RESET_PC` proceeds normally with `order = 0`.
- **Misaligned redirect:** redirect to `0x80000003` → `imem_addr = 0x80000000`.
